// File: rtl/exposure_sequencer.sv
// Timed exposure controller: opens/closes the shutter around a tick-counted
// exposure, then fires a two-cycle readout toggle and tracks readout busy.
// SETTLE_TICKS must be at least 1 and fit in EXP_WIDTH bits.
module exposure_sequencer #(
  parameter int TICK_DIV     = 100000,
  parameter int SETTLE_TICKS = 200,
  parameter int EXP_WIDTH    = 24,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 dark,
  input  logic [EXP_WIDTH-1:0] exp_ticks,
  input  logic                 readout_busy,
  output logic                 shutter_open,
  output logic                 readout_toggle,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 timeout,
  output logic [EXP_WIDTH-1:0] remaining
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [PRESC_W-1:0]   PRESC_LAST   = PRESC_W'(TICK_DIV - 1);
  localparam logic [EXP_WIDTH-1:0] SETTLE_LAST  = EXP_WIDTH'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    OPEN_SETTLE  = 3'd1,
    EXPOSE       = 3'd2,
    CLOSE_SETTLE = 3'd3,
    TRIGGER      = 3'd4,
    WAIT_START   = 3'd5,
    WAIT_READOUT = 3'd6
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic                   start_q_r;
  logic [EXP_WIDTH-1:0]   exp_lat_r, exp_nxt_s;
  logic                   dark_lat_r, dark_nxt_s;
  logic                   abort_close_r, abort_close_nxt_s;
  logic [PRESC_W-1:0]     presc_r, presc_nxt_s;
  logic [EXP_WIDTH-1:0]   tick_r, tick_nxt_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
  logic                   aborted_nxt_s, timeout_nxt_s, done_nxt_s;
  logic [EXP_WIDTH-1:0]   remaining_nxt_s;
  logic                   start_edge_s, wrap_s, timed_s;

  assign start_edge_s = start & ~start_q_r;
  assign wrap_s       = (presc_r == PRESC_LAST);
  assign timed_s      = (state_r == OPEN_SETTLE) || (state_r == EXPOSE) ||
                        (state_r == CLOSE_SETTLE);

  // Next-state, latched-parameter, flag and counter logic.
  always_comb begin
    state_nxt_s       = state_r;
    exp_nxt_s         = exp_lat_r;
    dark_nxt_s        = dark_lat_r;
    abort_close_nxt_s = abort_close_r;
    aborted_nxt_s     = aborted;
    timeout_nxt_s     = timeout;
    done_nxt_s        = 1'b0;
    presc_nxt_s       = presc_r;
    tick_nxt_s        = tick_r;
    cnt_nxt_s         = cnt_r;
    remaining_nxt_s   = {EXP_WIDTH{1'b0}};

    case (state_r)
      IDLE: begin
        if (start_edge_s) begin
          exp_nxt_s         = exp_ticks;
          dark_nxt_s        = dark;
          abort_close_nxt_s = 1'b0;
          aborted_nxt_s     = 1'b0;
          timeout_nxt_s     = 1'b0;
          if (!dark) begin
            state_nxt_s = OPEN_SETTLE;
          end else if (exp_ticks == {EXP_WIDTH{1'b0}}) begin
            state_nxt_s = TRIGGER;
          end else begin
            state_nxt_s = EXPOSE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OPEN_SETTLE: begin
        if (abort) begin
          aborted_nxt_s     = 1'b1;
          abort_close_nxt_s = 1'b1;
          state_nxt_s       = CLOSE_SETTLE;
        end else if (wrap_s && (tick_r == SETTLE_LAST)) begin
          // A zero-length exposure skips straight to closing.
          state_nxt_s = (exp_lat_r == {EXP_WIDTH{1'b0}}) ? CLOSE_SETTLE : EXPOSE;
        end else begin
          state_nxt_s = OPEN_SETTLE;
        end
      end
      EXPOSE: begin
        if (abort) begin
          aborted_nxt_s = 1'b1;
          if (!dark_lat_r) begin
            abort_close_nxt_s = 1'b1;
            state_nxt_s       = CLOSE_SETTLE;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (wrap_s && (tick_r == exp_lat_r - {{(EXP_WIDTH-1){1'b0}}, 1'b1})) begin
          state_nxt_s = dark_lat_r ? TRIGGER : CLOSE_SETTLE;
        end else begin
          state_nxt_s = EXPOSE;
        end
      end
      CLOSE_SETTLE: begin
        if (wrap_s && (tick_r == SETTLE_LAST)) begin
          state_nxt_s = abort_close_r ? IDLE : TRIGGER;
        end else begin
          state_nxt_s = CLOSE_SETTLE;
        end
      end
      TRIGGER: begin
        if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_nxt_s = WAIT_START;
        end else begin
          state_nxt_s = TRIGGER;
        end
      end
      WAIT_START: begin
        if (readout_busy) begin
          state_nxt_s = WAIT_READOUT;
        end else if (cnt_r == TIMEOUT_LAST) begin
          timeout_nxt_s = 1'b1;
          state_nxt_s   = IDLE;
        end else begin
          state_nxt_s = WAIT_START;
        end
      end
      WAIT_READOUT: begin
        if (!readout_busy) begin
          done_nxt_s  = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_READOUT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // Every state change restarts the prescaler, tick and cycle counters.
    if (state_nxt_s != state_r) begin
      presc_nxt_s = {PRESC_W{1'b0}};
      tick_nxt_s  = {EXP_WIDTH{1'b0}};
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else if (timed_s) begin
      if (wrap_s) begin
        presc_nxt_s = {PRESC_W{1'b0}};
        tick_nxt_s  = tick_r + {{(EXP_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        presc_nxt_s = presc_r + {{(PRESC_W-1){1'b0}}, 1'b1};
      end
    end else if ((state_r == TRIGGER) || (state_r == WAIT_START)) begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end

    // Remaining ticks only track EXPOSE; it reads 0 everywhere else.
    if (state_nxt_s == EXPOSE) begin
      if (state_r != EXPOSE) begin
        remaining_nxt_s = exp_nxt_s;
      end else if (wrap_s && (remaining != {EXP_WIDTH{1'b0}})) begin
        remaining_nxt_s = remaining - {{(EXP_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        remaining_nxt_s = remaining;
      end
    end else begin
      remaining_nxt_s = {EXP_WIDTH{1'b0}};
    end
  end

  // State, counters and registered outputs (derived from the next state).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      start_q_r      <= 1'b0;
      exp_lat_r      <= {EXP_WIDTH{1'b0}};
      dark_lat_r     <= 1'b0;
      abort_close_r  <= 1'b0;
      presc_r        <= {PRESC_W{1'b0}};
      tick_r         <= {EXP_WIDTH{1'b0}};
      cnt_r          <= {CNT_W{1'b0}};
      shutter_open   <= 1'b0;
      readout_toggle <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      timeout        <= 1'b0;
      remaining      <= {EXP_WIDTH{1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      start_q_r      <= start;
      exp_lat_r      <= exp_nxt_s;
      dark_lat_r     <= dark_nxt_s;
      abort_close_r  <= abort_close_nxt_s;
      presc_r        <= presc_nxt_s;
      tick_r         <= tick_nxt_s;
      cnt_r          <= cnt_nxt_s;
      shutter_open   <= (state_nxt_s == OPEN_SETTLE) ||
                        ((state_nxt_s == EXPOSE) && !dark_nxt_s);
      readout_toggle <= (state_nxt_s == TRIGGER);
      busy           <= (state_nxt_s != IDLE);
      done           <= done_nxt_s;
      aborted        <= aborted_nxt_s;
      timeout        <= timeout_nxt_s;
      remaining      <= remaining_nxt_s;
    end
  end

endmodule

// File: tb/tb_exposure_sequencer.sv
// Bench for exposure_sequencer: phase-arithmetic model checked every cycle,
// plus literal expectations at the key cycles of each directed scenario.
module tb_exposure_sequencer;

  localparam int TD     = 4;
  localparam int ST     = 2;
  localparam int BT     = 16;
  localparam int RB_DLY = 3;
  localparam int L      = 50;
  localparam int NRUN   = 8;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, dark, readout_busy;
  logic [23:0] exp_ticks;
  logic        shutter_open, readout_toggle, busy, done, aborted, timeout;
  logic [23:0] remaining;

  int n_cmp = 0;
  int n_bad = 0;

  // Scenario table: normal, dark, abort, timeout, after-timeout, zero+restart, reset, fresh.
  int sc_exp  [NRUN] = '{3, 3, 3, 3, 3, 0, 3, 3};
  int sc_dark [NRUN] = '{0, 1, 0, 0, 0, 0, 0, 0};
  int sc_ab   [NRUN] = '{-1, -1, 10, -1, -1, -1, -1, -1};
  int sc_rbl  [NRUN] = '{10, 10, 10, 0, 10, 10, 10, 10};
  int sc_rst  [NRUN] = '{-1, -1, -1, -1, -1, -1, 12, -1};
  int sc_s2   [NRUN] = '{-1, -1, -1, -1, -1, 12, -1, -1};

  typedef struct packed {
    logic        sh;
    logic        tg;
    logic        bz;
    logic        dn;
    logic        ab;
    logic        to;
    logic [23:0] rem;
  } exp_t;

  logic        sh_log [0:63];
  logic        tg_log [0:63];
  logic        bz_log [0:63];
  logic        dn_log [0:63];
  logic        ab_log [0:63];
  logic        to_log [0:63];
  logic [23:0] rem_log[0:63];

  exposure_sequencer #(
    .TICK_DIV(TD), .SETTLE_TICKS(ST), .EXP_WIDTH(24), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dark(dark),
    .exp_ticks(exp_ticks), .readout_busy(readout_busy),
    .shutter_open(shutter_open), .readout_toggle(readout_toggle), .busy(busy),
    .done(done), .aborted(aborted), .timeout(timeout), .remaining(remaining)
  );

  always #5 clk = ~clk;

  // First toggle cycle, counted from the start edge.
  function automatic int t0_of(input int r);
    int open_len;
    open_len = sc_dark[r] ? 0 : ST * TD;
    return open_len + sc_exp[r] * TD + open_len + 1;
  endfunction

  // Readout responder: busy rises RB_DLY cycles after the toggle for sc_rbl cycles.
  function automatic logic rb_level(input int r, input int p);
    int t0;
    t0 = t0_of(r);
    return (sc_rbl[r] > 0) && (p >= t0 + RB_DLY) && (p < t0 + RB_DLY + sc_rbl[r]);
  endfunction

  // Expected outputs at cycle c of run r, from the phase lengths alone.
  function automatic exp_t model(input int r, input int c);
    exp_t e;
    int open_len, close_len, ex_s, cs_s, t0, ws, cb, fin;
    logic rdo;
    e = '0;
    if (sc_rst[r] >= 0 && c > sc_rst[r]) return e;
    open_len  = sc_dark[r] ? 0 : ST * TD;
    close_len = open_len;
    ex_s = open_len + 1;
    cs_s = ex_s + sc_exp[r] * TD;
    t0   = cs_s + close_len;
    ws   = t0 + 2;
    if (sc_ab[r] >= 1 && sc_ab[r] < cs_s && c > sc_ab[r]) begin
      e.ab = 1'b1;
      e.bz = (c <= sc_ab[r] + close_len);
      return e;
    end
    cb  = (ws > t0 + RB_DLY) ? ws : t0 + RB_DLY;
    rdo = (sc_rbl[r] > 0) && (cb < ws + BT) && (cb < t0 + RB_DLY + sc_rbl[r]);
    if (rdo) begin
      fin = t0 + RB_DLY + sc_rbl[r] + 1;
    end else begin
      fin = ws + BT;
      e.to = (c >= fin);
    end
    e.bz  = (c < fin);
    e.dn  = rdo && (c == fin);
    e.sh  = (sc_dark[r] == 0) && (c < cs_s);
    e.tg  = (c == t0) || (c == t0 + 1);
    e.rem = (c >= ex_s && c < cs_s) ? 24'(sc_exp[r] - (c - ex_s) / TD) : 24'd0;
    return e;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  initial begin
    exp_t e;
    int n_sh, n_tg, n_dn, c;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dark = 1'b0;
    readout_busy = 1'b0; exp_ticks = 24'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        int'({shutter_open, readout_toggle, busy, done, aborted, timeout, remaining}), 0);
    rst_n = 1'b1;

    for (int r = 0; r < NRUN; r++) begin
      n_sh = 0; n_tg = 0; n_dn = 0;
      for (int p = 0; p <= L; p++) begin
        start        = (p == 0) || (p == sc_s2[r]);
        abort        = (p == sc_ab[r]);
        rst_n        = (p != sc_rst[r]);
        readout_busy = rb_level(r, p);
        dark         = (sc_dark[r] != 0);
        exp_ticks    = 24'(sc_exp[r]);
        @(posedge clk);
        #1;
        c = p + 1;
        e = model(r, c);
        chk($sformatf("r%0d c%0d shutter_open", r, c), int'(shutter_open), int'(e.sh));
        chk($sformatf("r%0d c%0d readout_toggle", r, c), int'(readout_toggle), int'(e.tg));
        chk($sformatf("r%0d c%0d busy", r, c), int'(busy), int'(e.bz));
        chk($sformatf("r%0d c%0d done", r, c), int'(done), int'(e.dn));
        chk($sformatf("r%0d c%0d aborted", r, c), int'(aborted), int'(e.ab));
        chk($sformatf("r%0d c%0d timeout", r, c), int'(timeout), int'(e.to));
        chk($sformatf("r%0d c%0d remaining", r, c), int'(remaining), int'(e.rem));
        sh_log[c] = shutter_open; tg_log[c] = readout_toggle; bz_log[c] = busy;
        dn_log[c] = done; ab_log[c] = aborted; to_log[c] = timeout;
        rem_log[c] = remaining;
        n_sh += int'(shutter_open); n_tg += int'(readout_toggle); n_dn += int'(done);
      end

      case (r)
        0: begin
          chk("normal sh@1", int'(sh_log[1]), 1);
          chk("normal sh@20", int'(sh_log[20]), 1);
          chk("normal sh@21", int'(sh_log[21]), 0);
          chk("normal tg@28", int'(tg_log[28]), 0);
          chk("normal tg@29", int'(tg_log[29]), 1);
          chk("normal tg@30", int'(tg_log[30]), 1);
          chk("normal tg@31", int'(tg_log[31]), 0);
          chk("normal busy@42", int'(bz_log[42]), 1);
          chk("normal done@43", int'(dn_log[43]), 1);
          chk("normal busy@43", int'(bz_log[43]), 0);
          chk("normal done_count", n_dn, 1);
        end
        1: begin
          chk("dark sh_count", n_sh, 0);
          chk("dark tg@12", int'(tg_log[12]), 0);
          chk("dark tg@13", int'(tg_log[13]), 1);
          chk("dark tg@14", int'(tg_log[14]), 1);
          chk("dark rem@4", int'(rem_log[4]), 3);
          chk("dark rem@5", int'(rem_log[5]), 2);
          chk("dark rem@9", int'(rem_log[9]), 1);
          chk("dark rem@13", int'(rem_log[13]), 0);
        end
        2: begin
          chk("abort sh@10", int'(sh_log[10]), 1);
          chk("abort sh@11", int'(sh_log[11]), 0);
          chk("abort busy@18", int'(bz_log[18]), 1);
          chk("abort busy@19", int'(bz_log[19]), 0);
          chk("abort aborted@19", int'(ab_log[19]), 1);
          chk("abort tg_count", n_tg, 0);
          chk("abort done_count", n_dn, 0);
        end
        3: begin
          chk("tmo timeout@46", int'(to_log[46]), 0);
          chk("tmo timeout@47", int'(to_log[47]), 1);
          chk("tmo busy@47", int'(bz_log[47]), 0);
          chk("tmo done_count", n_dn, 0);
        end
        4: begin
          chk("restart timeout@1", int'(to_log[1]), 0);
          chk("restart done_count", n_dn, 1);
        end
        5: begin
          chk("zero sh_count", n_sh, 8);
          chk("zero tg@17", int'(tg_log[17]), 1);
          chk("zero done_count", n_dn, 1);
        end
        6: begin
          chk("rst sh@12", int'(sh_log[12]), 1);
          chk("rst busy@12", int'(bz_log[12]), 1);
          chk("rst sh@13", int'(sh_log[13]), 0);
          chk("rst busy@13", int'(bz_log[13]), 0);
          chk("rst rem@13", int'(rem_log[13]), 0);
          chk("rst tg_count", n_tg, 0);
        end
        7: begin
          chk("fresh sh_count", n_sh, 20);
          chk("fresh done@43", int'(dn_log[43]), 1);
        end
        default: begin
          chk("run index", r, 0);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
